// File: rtl/port_sched_ctrl.sv
// Output-port packet scheduler: strict-priority or 8-queue weighted round robin
// selection feeding an IDLE/GRANT/BUSY handshake. Define SCHED_STAT_EN to add grant_cnt.
module port_sched_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] queue_nonempty,
    input  logic       ready,
    input  logic       wrr_enable,
    input  logic       pkt_done,
    output logic       grant,
    output logic [2:0] grant_prio,
    output logic       busy
`ifdef SCHED_STAT_EN
    ,
    output logic [15:0] grant_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [7:0][3:0]  credit;
    logic [7:0]       eligible;
    logic [7:0]       cand;
    logic             reload;
    logic             decide;
    logic [2:0]       sel;

    function automatic logic [2:0] top_idx(input logic [7:0] v);
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) top_idx = 3'(i);
    endfunction

    always_comb begin
        for (int p = 0; p < 8; p++)
            eligible[p] = queue_nonempty[p] && (credit[p] != 4'd0);
    end

    // When no nonempty queue has credit left, the decision uses freshly
    // reloaded weights, all of which are nonzero, so the nonempty set itself wins.
    assign reload = wrr_enable && (eligible == 8'd0);
    assign cand   = (!wrr_enable || reload) ? queue_nonempty : eligible;
    assign sel    = top_idx(cand);
    assign decide = (state == IDLE) && ready && (queue_nonempty != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (decide)   state_nxt = GRANT;
            GRANT:   state_nxt = pkt_done ? IDLE : BUSY;
            BUSY:    if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant = (state == GRANT);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         grant_prio <= 3'd0;
        else if (decide) grant_prio <= sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 8; p++) credit[p] <= 4'(p + 1);
        end else if (decide && wrr_enable) begin
            for (int p = 0; p < 8; p++) begin
                if (reload)
                    credit[p] <= (3'(p) == sel) ? 4'(p) : 4'(p + 1);
                else if ((3'(p) == sel) && (credit[p] != 4'd0))
                    credit[p] <= credit[p] - 4'd1;
            end
        end
    end

`ifdef SCHED_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              grant_cnt <= 16'd0;
        else if (decide && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_port_sched_ctrl.sv
// Directed bench for port_sched_ctrl; expected grant priorities go through a
// scoreboard queue pushed at stimulus time and popped at each observed grant.
module tb_port_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] queue_nonempty;
    logic       ready;
    logic       wrr_enable;
    logic       pkt_done;
    logic       grant;
    logic [2:0] grant_prio;
    logic       busy;
`ifdef SCHED_STAT_EN
    logic [15:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    port_sched_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .queue_nonempty (queue_nonempty),
        .ready          (ready),
        .wrr_enable     (wrr_enable),
        .pkt_done       (pkt_done),
        .grant          (grant),
        .grant_prio     (grant_prio),
        .busy           (busy)
`ifdef SCHED_STAT_EN
        ,
        .grant_cnt      (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag);
        int e;
        check({tag, "_grant"}, {15'd0, grant}, 16'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_prio"}, {13'd0, grant_prio}, 16'(e));
        end
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (grant) break;
            tick();
        end
        expect_grant(tag);
    endtask

    // grant seen now; pkt_done raised two cycles later, then back in IDLE
    task automatic finish_pkt(input string tag);
        tick();
        tick();
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        check({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_idle_grant"}, {15'd0, grant}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; queue_nonempty = 8'd0; ready = 1'b0; wrr_enable = 1'b0; pkt_done = 1'b0;
        #3;
        check("rst_grant", {15'd0, grant}, 16'd0);
        check("rst_busy",  {15'd0, busy}, 16'd0);
        check("rst_prio",  {13'd0, grant_prio}, 16'd0);
        for (int p = 0; p < 8; p++) check($sformatf("rst_credit%0d", p), {12'd0, dut.credit[p]}, 16'(p + 1));
        tick(); tick();
        rst = 1'b0;
        tick();

        // strict priority, single-cycle ready
        wrr_enable = 1'b0; queue_nonempty = 8'h38; ready = 1'b1;
        exp_q.push_back(5);
        check("strict_pre_grant", {15'd0, grant}, 16'd0);
        tick();
        expect_grant("strict");
        check("strict_busy_g", {15'd0, busy}, 16'd1);
        ready = 1'b0; queue_nonempty = 8'h80; wrr_enable = 1'b1;
        tick();
        check("strict_one_cycle", {15'd0, grant}, 16'd0);
        check("strict_busy_b", {15'd0, busy}, 16'd1);
        check("strict_prio_hold", {13'd0, grant_prio}, 16'd5);
        tick(); tick();
        check("strict_busy_hold", {15'd0, busy}, 16'd1);
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        check("strict_done_busy", {15'd0, busy}, 16'd0);
        check("strict_credit5", {12'd0, dut.credit[5]}, 16'd6);
        check("strict_credit7", {12'd0, dut.credit[7]}, 16'd8);

        // WRR with queues 0 and 1
        wrr_enable = 1'b1; queue_nonempty = 8'h03; ready = 1'b1;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        for (int k = 0; k < 6; k++) begin
            wait_grant($sformatf("wrr%0d", k));
            finish_pkt($sformatf("wrr%0d", k));
        end

        // single queue 7, credit exhaustion and reload
        queue_nonempty = 8'h80;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(7);
            wait_grant($sformatf("rl%0d", k));
            if (k == 7) check("rl_credit7_zero", {12'd0, dut.credit[7]}, 16'd0);
            finish_pkt($sformatf("rl%0d", k));
        end
        check("rl_credit7_after", {12'd0, dut.credit[7]}, 16'd7);

        // pkt_done during the grant cycle
        ready = 1'b0;
        tick();
        wrr_enable = 1'b0; queue_nonempty = 8'h01; ready = 1'b1;
        exp_q.push_back(0);
        tick();
        expect_grant("gd_first");
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        check("gd_idle_busy", {15'd0, busy}, 16'd0);
        check("gd_idle_grant", {15'd0, grant}, 16'd0);
        exp_q.push_back(0);
        tick();
        expect_grant("gd_second");
        ready = 1'b0;
        pkt_done = 1'b1;
        tick();
        check("gd_end_busy", {15'd0, busy}, 16'd0);
        tick();
        pkt_done = 1'b0;
        check("idle_done_ignored", {15'd0, busy}, 16'd0);

        // async reset mid-packet
        wrr_enable = 1'b1; queue_nonempty = 8'h80; ready = 1'b1;
        exp_q.push_back(7);
        tick();
        expect_grant("ar_pre");
        ready = 1'b0;
        tick();
        check("ar_busy_before", {15'd0, busy}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", {15'd0, busy}, 16'd0);
        check("ar_grant", {15'd0, grant}, 16'd0);
        check("ar_prio", {13'd0, grant_prio}, 16'd0);
        for (int p = 0; p < 8; p++) check($sformatf("ar_credit%0d", p), {12'd0, dut.credit[p]}, 16'(p + 1));
        #1 rst = 1'b0;
        tick();
        check("ar_no_grant", {15'd0, grant}, 16'd0);
        ready = 1'b1;
        exp_q.push_back(7);
        check("ar_ready_pre", {15'd0, grant}, 16'd0);
        tick();
        expect_grant("ar_post");
        ready = 1'b0;
        finish_pkt("ar_post");

`ifdef SCHED_STAT_EN
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(7);
            wait_grant($sformatf("st%0d", k));
            finish_pkt($sformatf("st%0d", k));
        end
        check("stat_cnt3", grant_cnt, 16'd3);
        ready = 1'b0;
        force dut.grant_cnt = 16'hFFFF;
        tick();
        release dut.grant_cnt;
        ready = 1'b1;
        exp_q.push_back(7);
        wait_grant("st_sat");
        ready = 1'b0;
        finish_pkt("st_sat");
        check("stat_sat", grant_cnt, 16'hFFFF);
`endif

        check("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_sched_ctrl.md
PORT_SCHED_CTRL -- requirements
Module: port_sched_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port queue_nonempty, input, 8 bits: bit p = priority-p queue of this output port holds at least one complete packet.
REQ-004 SHALL have port ready, input, 1 bit: downstream output port accepts a new packet.
REQ-005 SHALL have port wrr_enable, input, 1 bit: 1 = weighted round robin (WRR), 0 = strict priority.
REQ-006 SHALL have port pkt_done, input, 1 bit: one-cycle pulse, the granted packet's rd_eop has been sent.
REQ-007 SHALL have port grant, output, 1 bit: one-cycle pulse, start reading the queue on grant_prio.
REQ-008 SHALL have port grant_prio, output, 3 bits: priority of the last grant, held until the next grant.
REQ-009 SHALL have port busy, output, 1 bit: high from the grant cycle until packet completion.

Function
REQ-010 SHALL implement a 3-state FSM with states IDLE, GRANT and BUSY.
REQ-011 SHALL go IDLE->GRANT when, in IDLE, ready=1 and queue_nonempty!=0; otherwise SHALL stay in IDLE.
REQ-012 SHALL drive grant=1 in GRANT only, so grant rises exactly 1 cycle after the sampled ready/nonempty cycle.
REQ-013 SHALL go GRANT->BUSY unconditionally, except that pkt_done=1 in GRANT SHALL go GRANT->IDLE.
REQ-014 SHALL go BUSY->IDLE on pkt_done=1; pkt_done in IDLE SHALL be ignored.
REQ-015 SHALL drive busy=1 in GRANT and BUSY, and busy=0 in IDLE.
REQ-016 SHALL leave at least one IDLE cycle between consecutive grants, even when pkt_done and ready are both 1.
REQ-017 SHALL, with wrr_enable=0, select the highest-index nonempty queue (7 highest priority).
REQ-018 SHALL keep one 4-bit credit counter per queue, with weight[p]=p+1 (queue 0=1 ... queue 7=8).
REQ-019 SHALL, with wrr_enable=1, select the highest-index queue that is nonempty and has credit>0.
REQ-020 SHALL decrement the winner's credit by 1 on each WRR grant, with no underflow.
REQ-021 SHALL, when every nonempty queue has credit 0 at the decision cycle, reload all 8 credits to their weights in that same cycle, select from the reloaded values, and then decrement the winner.
REQ-022 SHALL leave credits unmodified in strict mode, and SHALL resume from the held credits when wrr_enable returns to 1.
REQ-023 SHALL sample wrr_enable and queue_nonempty only in the IDLE decision cycle; changes while busy SHALL have no effect on the current grant.
REQ-024 SHALL latch the selection into grant_prio on entry to GRANT.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, set state=IDLE, grant=0, busy=0, grant_prio=0, credits=weights.
REQ-026 SHALL, on rst asserted mid-packet (GRANT/BUSY), abort to IDLE immediately; the first grant after deassertion SHALL come no earlier than 1 cycle after the first sampled ready=1.

Configuration
REQ-027 SHALL, when macro SCHED_STAT_EN is defined, add output grant_cnt, 16 bits, counting grants, saturating at 16'hFFFF, reset to 0.
REQ-028 SHALL, when SCHED_STAT_EN is undefined, have no grant_cnt port or counter logic, with all other behaviour identical.

Verification
REQ-029 SHALL cover strict mode: wrr_enable=0, nonempty=8'h38, ready pulse 1 cycle -> grant 1 cycle later with grant_prio=5, busy held until pkt_done.
REQ-030 SHALL cover WRR sequence: wrr_enable=1, nonempty=8'h03 held, ready=1, pkt_done 2 cycles after each grant -> grant_prio sequence 1,1,0,1,1,0.
REQ-031 SHALL cover reload: nonempty=8'h80, 9 packets in WRR -> 9 grants with prio 7; reload occurs at the 9th decision and credit[7]=7 afterwards.
REQ-032 SHALL cover pkt_done in GRANT: pkt_done asserted in the grant cycle -> IDLE next cycle, busy=0, next grant at least 2 cycles later.
REQ-033 SHALL cover async reset in BUSY: rst pulsed mid-packet -> busy=0 and grant=0 with no clock edge, credits back to 1..8.
REQ-034 SHALL cover SCHED_STAT_EN: 3 grants -> grant_cnt=3; forced at 16'hFFFF plus 1 grant -> stays 16'hFFFF.
